// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and the
// nibble width handled per clock.
package nsa_defs;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand and result handshake bundle of the nibble-serial adder.
// The master drives operands and consumes results; the slave is the adder.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/nibble_serial_adder_rca.sv
// 4-bit ripple-carry adder, purely combinational; the datapath reused by the
// nibble-serial adder.
module rca (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic carry;

  // NOTE: blocking assignments here on purpose -- carry is a ripple temporary
  // that each loop iteration reads after the previous one wrote it.
  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < 4; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: computes a + b + cin one nibble per clock through
// a single 4-bit ripple-carry adder, with the carry registered between nibbles.
module nibble_serial_adder
  import nsa_defs::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);

  localparam int N  = WIDTH / NIB;
  localparam int CW = $clog2(N) + 1;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    cnt;
  logic [NIB-1:0]   nib_s;
  logic             nib_c;

  rca u_rca (
    .a    (a_sh[NIB-1:0]),
    .b    (b_sh[NIB-1:0]),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_c)
  );

  // Operands are only ever sampled on the accepting edge, so X on a/b while
  // the block is busy never reaches the shift registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, matching the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // Each nibble result enters at the top so the LSB nibble ends at bit 0.
          sum_r <= (sum_r >> NIB) | (WIDTH'(nib_s) << (WIDTH - NIB));
          a_sh  <= a_sh >> NIB;
          b_sh  <= b_sh >> NIB;
          carry <= nib_c;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            cout_r <= nib_c;
            state  <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: a 16-bit and a 4-bit build share
// clock and reset; expected results are queued on accept and popped on out_valid.
module tb_nibble_serial_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [16:0] q16[$];
  logic [4:0]  q4[$];

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  // ---------------- 16-bit helpers ----------------
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c);
    int w = 0;
    while (bus16.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (bus16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send16_ready: in_ready=%b required 1", bus16.in_ready);
      return;
    end
    bus16.in_valid = 1'b1;
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = c;
    q16.push_back({1'b0, a} + {1'b0, b} + {16'd0, c});
    @(posedge clk);
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.a        = 'x;
    bus16.b        = 'x;
  endtask

  task automatic recv16(input int hold);
    int lat = 0;
    logic [16:0] exp;
    while (bus16.out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 4) begin
      n_fail++;
      $display("FAIL latency16: got %0d edges required 4", lat);
    end
    if (bus16.out_valid !== 1'b1 || q16.size() == 0) return;
    exp = q16.pop_front();
    for (int i = 0; i <= hold; i++) begin
      n_checks++;
      if ({bus16.cout, bus16.sum} !== exp) begin
        n_fail++;
        $display("FAIL sum16: got cout=%b sum=%h required cout=%b sum=%h",
                 bus16.cout, bus16.sum, exp[16], exp[15:0]);
      end
      n_checks++;
      if (bus16.out_valid !== 1'b1 || bus16.in_ready !== 1'b0 || bus16.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold16: out_valid=%b in_ready=%b busy=%b required 1 0 1",
                 bus16.out_valid, bus16.in_ready, bus16.busy);
      end
      if (i < hold) @(negedge clk);
    end
    bus16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.out_ready = 1'b0;
    n_checks++;
    if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1 || bus16.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pop16: out_valid=%b in_ready=%b busy=%b required 0 1 0",
               bus16.out_valid, bus16.in_ready, bus16.busy);
    end
  endtask

  // ---------------- 4-bit helpers ----------------
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int w = 0;
    while (bus4.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_checks++;
    if (bus4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send4_ready: in_ready=%b required 1", bus4.in_ready);
      return;
    end
    bus4.in_valid = 1'b1;
    bus4.a        = a;
    bus4.b        = b;
    bus4.cin      = c;
    q4.push_back({1'b0, a} + {1'b0, b} + {4'd0, c});
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.a        = 'x;
    bus4.b        = 'x;
  endtask

  task automatic recv4(input int hold);
    int lat = 0;
    logic [4:0] exp;
    while (bus4.out_valid !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 1) begin
      n_fail++;
      $display("FAIL latency4: got %0d edges required 1", lat);
    end
    if (bus4.out_valid !== 1'b1 || q4.size() == 0) return;
    exp = q4.pop_front();
    for (int i = 0; i <= hold; i++) begin
      n_checks++;
      if ({bus4.cout, bus4.sum} !== exp) begin
        n_fail++;
        $display("FAIL sum4: got cout=%b sum=%h required cout=%b sum=%h",
                 bus4.cout, bus4.sum, exp[4], exp[3:0]);
      end
      if (i < hold) @(negedge clk);
    end
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    n_checks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pop4: out_valid=%b in_ready=%b required 0 1",
               bus4.out_valid, bus4.in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus16.in_valid = 1'b0; bus16.a = 'x; bus16.b = 'x; bus16.cin = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.a  = 'x; bus4.b  = 'x; bus4.cin  = 1'b0; bus4.out_ready  = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus16.in_ready, bus16.out_valid, bus16.busy, bus16.cout} !== 4'b1000 || bus16.sum !== 16'h0) begin
      n_fail++;
      $display("FAIL reset16: rdy/vld/busy/cout=%b sum=%h required 1000 0000",
               {bus16.in_ready, bus16.out_valid, bus16.busy, bus16.cout}, bus16.sum);
    end
    n_checks++;
    if ({bus4.in_ready, bus4.out_valid, bus4.busy, bus4.cout} !== 4'b1000 || bus4.sum !== 4'h0) begin
      n_fail++;
      $display("FAIL reset4: rdy/vld/busy/cout=%b sum=%h required 1000 0",
               {bus4.in_ready, bus4.out_valid, bus4.busy, bus4.cout}, bus4.sum);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus16.in_ready !== 1'b1 || bus16.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_x16: in_ready=%b busy=%b required 1 0", bus16.in_ready, bus16.busy);
    end
  endtask

  task automatic test_basic();
    send16(16'h1234, 16'h4321, 1'b0); recv16(0);
    send16(16'hFFFF, 16'h0001, 1'b0); recv16(0);
    send16(16'hFFFF, 16'h0000, 1'b1); recv16(0);
    send16(16'h8000, 16'h8000, 1'b1); recv16(1);
  endtask

  task automatic test_backpressure();
    send16(16'h0F0F, 16'hF0F1, 1'b0);
    bus16.in_valid = 1'b1;
    bus16.a        = 16'hABCD;
    bus16.b        = 16'h1111;
    bus16.cin      = 1'b1;
    recv16(5);
    send16(16'hABCD, 16'h1111, 1'b1);
    recv16(0);
  endtask

  task automatic test_reset_mid_run();
    send16(16'h1234, 16'h1111, 1'b0);
    void'(q16.pop_back());
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0 || bus16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort16: out_valid=%b sum=%h in_ready=%b required 0 0000 1",
               bus16.out_valid, bus16.sum, bus16.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL after_abort16: out_valid=%b in_ready=%b required 0 1",
                 bus16.out_valid, bus16.in_ready);
      end
    end
    send16(16'h00FF, 16'h0001, 1'b0);
    recv16(0);
  endtask

  task automatic test_width4();
    send4(4'h9, 4'h8, 1'b0); recv4(0);
    for (int i = 0; i < 1000; i++) begin
      send4(4'($urandom), 4'($urandom), 1'($urandom));
      recv4(int'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_random16();
    for (int i = 0; i < 60; i++) begin
      send16(16'($urandom), 16'($urandom), 1'($urandom));
      recv16(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    test_random16();
    n_checks++;
    if (q16.size() != 0 || q4.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: q16=%0d q4=%0d entries left required 0",
               q16.size(), q4.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
